// File: rtl/avalon_data_outstanding_bridge.sv
// avalon_data_outstanding_bridge
// Pipelined bridge from the ibex data port (req/gnt/rvalid) to the 64-bit
// Avalon-MM main-memory master. Commands are issued combinationally, and up to
// MaxOutstanding transactions are tracked in issue order. Reads retire on
// readdatavalid, and writes are acknowledged locally.
// Optional feature: define AVALON_DATA_ERR_EN to report the Avalon response
// status on data_err_o for retired reads. When it is undefined, data_err_o is
// tied to 0 and the response status is not stored.
module avalon_data_outstanding_bridge #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [7:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [63:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [63:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] avm_main_address,
    output logic [7:0]  avm_main_byteenable,
    output logic        avm_main_read,
    output logic        avm_main_write,
    output logic [63:0] avm_main_writedata,
    input  logic        avm_main_waitrequest,
    input  logic        avm_main_readdatavalid,
    input  logic [63:0] avm_main_readdata,
    input  logic [1:0]  avm_main_response
);

    localparam int unsigned PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MaxOutstanding - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MaxOutstanding);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef AVALON_DATA_ERR_EN
    localparam int unsigned RSP_W = 66;  // {readdata, response}
`else
    localparam int unsigned RSP_W = 64;  // readdata only
`endif

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_e;

    // Order queue: one type entry per granted transaction.
    txn_e             ord_type [MaxOutstanding];
    logic [PTR_W-1:0] ord_wr_ptr, ord_rd_ptr;
    logic [CNT_W-1:0] ord_cnt;
    logic [CNT_W-1:0] rd_cnt;   // reads currently in the order queue

    // Response FIFO: read responses that arrived before their read reached the head.
    logic [RSP_W-1:0] rsp_mem [MaxOutstanding];
    logic [PTR_W-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [CNT_W-1:0] rsp_cnt;

    logic             full;
    logic             issue;
    logic             ord_push;
    logic             rd_push;
    logic             rsp_accept;
    logic             rsp_push;
    logic             rsp_pop;
    logic             retire;
    logic             retire_rd;
    logic [RSP_W-1:0] rsp_in;
    logic [RSP_W-1:0] rsp_sel;
    logic             unused_inputs;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return c + CNT_ONE;
            2'b01:   return c - CNT_ONE;
            default: return c;
        endcase
    endfunction

    // Command path. full looks only at the registered count, so a retire in
    // this cycle never opens a path from readdatavalid to data_gnt_o.
    assign full                = (ord_cnt == CNT_MAX);
    assign issue               = data_req_i & ~full & rst_ni;
    assign avm_main_read       = issue & ~data_we_i;
    assign avm_main_write      = issue & data_we_i;
    assign data_gnt_o          = issue & ~avm_main_waitrequest;
    assign avm_main_address    = {data_addr_i[31:3], 3'b000};
    assign avm_main_byteenable = data_be_i;
    assign avm_main_writedata  = data_wdata_i;

    assign ord_push = data_gnt_o;
    assign rd_push  = data_gnt_o & ~data_we_i;

`ifdef AVALON_DATA_ERR_EN
    assign rsp_in        = {avm_main_readdata, avm_main_response};
    assign unused_inputs = ^data_addr_i[2:0];
`else
    assign rsp_in        = avm_main_readdata;
    assign unused_inputs = ^{data_addr_i[2:0], avm_main_response};
`endif

    // A response is kept only if some queued read is still waiting for one.
    assign rsp_accept = avm_main_readdatavalid & (rd_cnt > rsp_cnt);

    // Retire selection: at most one transaction per cycle, stored data before bypass.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        retire    = 1'b0;
        retire_rd = 1'b0;
        rsp_pop   = 1'b0;
        rsp_push  = rsp_accept;
        rsp_sel   = rsp_mem[rsp_rd_ptr];
        if (ord_cnt != '0) begin
            if (ord_type[ord_rd_ptr] == TXN_WRITE) begin
                retire = 1'b1;
            end else if (rsp_cnt != '0) begin
                retire    = 1'b1;
                retire_rd = 1'b1;
                rsp_pop   = 1'b1;
            end else if (rsp_accept) begin
                retire    = 1'b1;
                retire_rd = 1'b1;
                rsp_push  = 1'b0;
                rsp_sel   = rsp_in;
            end
        end
    end

    // Queue pointers and occupancy counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            ord_wr_ptr <= '0;
            ord_rd_ptr <= '0;
            ord_cnt    <= '0;
            rd_cnt     <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_cnt    <= '0;
        end else begin
            if (ord_push) ord_wr_ptr <= ptr_next(ord_wr_ptr);
            if (retire)   ord_rd_ptr <= ptr_next(ord_rd_ptr);
            if (rsp_push) rsp_wr_ptr <= ptr_next(rsp_wr_ptr);
            if (rsp_pop)  rsp_rd_ptr <= ptr_next(rsp_rd_ptr);
            ord_cnt <= cnt_next(ord_cnt, ord_push, retire);
            rd_cnt  <= cnt_next(rd_cnt, rd_push, retire_rd);
            rsp_cnt <= cnt_next(rsp_cnt, rsp_push, rsp_pop);
        end
    end

    // Queue entry storage.
    always_ff @(posedge clk_i) begin
        // NOTE: payload arrays are not reset; the reset pointers and counts mark every entry invalid.
        if (ord_push) ord_type[ord_wr_ptr] <= txn_e'(data_we_i);
        if (rsp_push) rsp_mem[rsp_wr_ptr]  <= rsp_in;
    end

    // Registered response to the core; read data holds across write retires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_rvalid_o <= retire;
            if (retire_rd) data_rdata_o <= rsp_sel[RSP_W-1 -: 64];
        end
    end

`ifdef AVALON_DATA_ERR_EN
    // Error status of the retired transaction; writes always report OKAY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_err_o <= 1'b0;
        end else if (retire) begin
            data_err_o <= retire_rd & (rsp_sel[1:0] != 2'b00);
        end
    end
`else
    assign data_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
    // A response with no waiting read is dropped; flag it in simulation.
    rsp_orphan_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        avm_main_readdatavalid |-> (rd_cnt > rsp_cnt))
        else $warning("readdatavalid with no outstanding read, response dropped");
`endif

endmodule

// File: tb/tb_avalon_data_outstanding_bridge.sv
// tb_avalon_data_outstanding_bridge
// Directed scenarios plus a randomized run checked against a queue-based
// transaction model of the bridge.
`timescale 1ns/1ps
module tb_avalon_data_outstanding_bridge;

    localparam int MAX = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_we_i;
    logic [7:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [63:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [63:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] avm_main_address;
    logic [7:0]  avm_main_byteenable;
    logic        avm_main_read;
    logic        avm_main_write;
    logic [63:0] avm_main_writedata;
    logic        avm_main_waitrequest;
    logic        avm_main_readdatavalid;
    logic [63:0] avm_main_readdata;
    logic [1:0]  avm_main_response;

    always #5 clk_i = ~clk_i;

    avalon_data_outstanding_bridge #(.MaxOutstanding(MAX)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .data_req_i             (data_req_i),
        .data_we_i              (data_we_i),
        .data_be_i              (data_be_i),
        .data_addr_i            (data_addr_i),
        .data_wdata_i           (data_wdata_i),
        .data_gnt_o             (data_gnt_o),
        .data_rvalid_o          (data_rvalid_o),
        .data_rdata_o           (data_rdata_o),
        .data_err_o             (data_err_o),
        .avm_main_address       (avm_main_address),
        .avm_main_byteenable    (avm_main_byteenable),
        .avm_main_read          (avm_main_read),
        .avm_main_write         (avm_main_write),
        .avm_main_writedata     (avm_main_writedata),
        .avm_main_waitrequest   (avm_main_waitrequest),
        .avm_main_readdatavalid (avm_main_readdatavalid),
        .avm_main_readdata      (avm_main_readdata),
        .avm_main_response      (avm_main_response)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction model: issued transactions in order (1 = write) and
    // responses captured but not yet delivered.
    bit          mq[$];
    logic [65:0] mr[$];
    logic        cur_rvalid = 1'b0;
    logic        cur_err    = 1'b0;
    logic [63:0] cur_rdata  = '0;

    logic        exp_gnt, exp_read, exp_write, exp_rvalid, exp_err;
    logic [63:0] exp_rdata;
    logic        obs_gnt, obs_read, obs_write, obs_rvalid, obs_err;
    logic [63:0] obs_rdata, obs_wdata;
    logic [31:0] obs_addr;
    logic [7:0]  obs_be;

    function automatic int pending_reads();
        int n = 0;
        foreach (mq[i]) if (!mq[i]) n++;
        return n - mr.size();
    endfunction

    task automatic idle();
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
        data_addr_i = '0; data_wdata_i = '0;
        avm_main_waitrequest = 1'b0; avm_main_readdatavalid = 1'b0;
        avm_main_readdata = '0; avm_main_response = '0;
    endtask

    // One clock cycle: sample the DUT mid-cycle, predict, then advance the model.
    task automatic tick();
        logic [65:0] e;
        @(negedge clk_i);
        if (!rst_ni) begin
            mq.delete(); mr.delete();
            cur_rvalid = 1'b0; cur_rdata = '0; cur_err = 1'b0;
        end
        exp_rvalid = cur_rvalid; exp_rdata = cur_rdata; exp_err = cur_err;
        exp_read  = rst_ni && data_req_i && !data_we_i && (mq.size() < MAX);
        exp_write = rst_ni && data_req_i && data_we_i && (mq.size() < MAX);
        exp_gnt   = rst_ni && data_req_i && (mq.size() < MAX) && !avm_main_waitrequest;
        obs_gnt = data_gnt_o; obs_read = avm_main_read; obs_write = avm_main_write;
        obs_rvalid = data_rvalid_o; obs_rdata = data_rdata_o; obs_err = data_err_o;
        obs_addr = avm_main_address; obs_be = avm_main_byteenable; obs_wdata = avm_main_writedata;
        if (rst_ni) begin
            if (avm_main_readdatavalid && pending_reads() > 0)
                mr.push_back({avm_main_readdata, avm_main_response});
            cur_rvalid = 1'b0;
            if (mq.size() > 0) begin
                if (mq[0]) begin
                    void'(mq.pop_front());
                    cur_rvalid = 1'b1; cur_err = 1'b0;
                end else if (mr.size() > 0) begin
                    e = mr.pop_front();
                    void'(mq.pop_front());
                    cur_rvalid = 1'b1; cur_rdata = e[65:2];
`ifdef AVALON_DATA_ERR_EN
                    cur_err = (e[1:0] != 2'b00);
`else
                    cur_err = 1'b0;
`endif
                end
            end
            if (exp_gnt) mq.push_back(data_we_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0; idle();
        tick(); tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; idle(); data_req_i = 1'b1;
        tick();
        n_checks++; if (obs_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %0b want 0", obs_read); end
        n_checks++; if (obs_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_gnt: got %0b want 0", obs_gnt); end
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %0b want 0", obs_rvalid); end
        n_checks++; if (obs_rdata !== 64'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b want 0", obs_err); end
        data_we_i = 1'b1;
        tick();
        n_checks++; if (obs_write !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %0b want 0", obs_write); end
        rst_ni = 1'b1; idle();
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_release_rvalid: got %0b want 0", obs_rvalid); end
    endtask

    task automatic test_single_read();
        apply_reset();
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 8'hFF; data_addr_i = 32'h1000_0004;
        tick();
        n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL rd_gnt: got %0b want 1", obs_gnt); end
        n_checks++; if (obs_read !== 1'b1) begin n_errors++; $display("FAIL rd_cmd: got %0b want 1", obs_read); end
        n_checks++; if (obs_addr !== 32'h1000_0000) begin n_errors++; $display("FAIL rd_addr: got %h want 10000000", obs_addr); end
        idle();
        tick(); tick();
        avm_main_readdatavalid = 1'b1; avm_main_readdata = 64'hDEADBEEF_01234567;
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_early_rvalid: got %0b want 0", obs_rvalid); end
        idle();
        tick();
        n_checks++; if (obs_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_rvalid: got %0b want 1", obs_rvalid); end
        n_checks++; if (obs_rdata !== 64'hDEADBEEF_01234567) begin n_errors++; $display("FAIL rd_data: got %h want deadbeef01234567", obs_rdata); end
        n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL rd_err: got %0b want 0", obs_err); end
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL rd_single_pulse: got %0b want 0", obs_rvalid); end
    endtask

    task automatic test_write_wait();
        logic [63:0] wd;
        logic        want;
        apply_reset();
        wd = {$urandom(), $urandom()};
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 8'h0F;
        data_addr_i = $urandom(); data_wdata_i = wd; avm_main_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) avm_main_waitrequest = 1'b0;
            want = (c == 2);
            tick();
            n_checks++; if (obs_write !== 1'b1) begin n_errors++; $display("FAIL wr_cmd_c%0d: got %0b want 1", c, obs_write); end
            n_checks++; if (obs_gnt !== want) begin n_errors++; $display("FAIL wr_gnt_c%0d: got %0b want %0b", c, obs_gnt, want); end
        end
        n_checks++; if (obs_be !== 8'h0F) begin n_errors++; $display("FAIL wr_be: got %h want 0f", obs_be); end
        n_checks++; if (obs_wdata !== wd) begin n_errors++; $display("FAIL wr_data: got %h want %h", obs_wdata, wd); end
        idle();
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_rvalid_n1: got %0b want 0", obs_rvalid); end
        tick();
        n_checks++; if (obs_rvalid !== 1'b1) begin n_errors++; $display("FAIL wr_rvalid_n2: got %0b want 1", obs_rvalid); end
        n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL wr_err: got %0b want 0", obs_err); end
    endtask

    task automatic test_full();
        logic [63:0] d;
        apply_reset();
        d = {$urandom(), $urandom()};
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            data_addr_i = $urandom();
            tick();
            n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL full_gnt_%0d: got %0b want 1", c, obs_gnt); end
        end
        data_addr_i = $urandom();
        tick();
        n_checks++; if (obs_gnt !== 1'b0 || obs_read !== 1'b0) begin n_errors++; $display("FAIL full_block: got gnt=%0b read=%0b want 0/0", obs_gnt, obs_read); end
        avm_main_readdatavalid = 1'b1; avm_main_readdata = d;
        tick();
        n_checks++; if (obs_gnt !== 1'b0 || obs_read !== 1'b0) begin n_errors++; $display("FAIL full_retire_cycle: got gnt=%0b read=%0b want 0/0", obs_gnt, obs_read); end
        avm_main_readdatavalid = 1'b0;
        tick();
        n_checks++; if (obs_gnt !== 1'b1 || obs_read !== 1'b1) begin n_errors++; $display("FAIL full_unblock: got gnt=%0b read=%0b want 1/1", obs_gnt, obs_read); end
        n_checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== d) begin n_errors++; $display("FAIL full_retire: got rvalid=%0b data=%h want 1/%h", obs_rvalid, obs_rdata, d); end
        idle();
    endtask

    task automatic test_wrr();
        logic [63:0] d1, d2;
        apply_reset();
        d1 = {$urandom(), $urandom()};
        d2 = {$urandom(), $urandom()};
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 8'hFF; data_wdata_i = {$urandom(), $urandom()};
        tick();
        n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL wrr_gnt_w: got %0b want 1", obs_gnt); end
        data_we_i = 1'b0; data_addr_i = $urandom();
        tick();
        n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL wrr_gnt_r1: got %0b want 1", obs_gnt); end
        data_addr_i = $urandom();
        tick();
        n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL wrr_gnt_r2: got %0b want 1", obs_gnt); end
        n_checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0 || obs_err !== 1'b0) begin n_errors++; $display("FAIL wrr_w_retire: got rvalid=%0b data=%h err=%0b want 1/0/0", obs_rvalid, obs_rdata, obs_err); end
        idle();
        avm_main_readdatavalid = 1'b1; avm_main_readdata = d1;
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL wrr_gap: got %0b want 0", obs_rvalid); end
        avm_main_readdata = d2;
        tick();
        n_checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== d1) begin n_errors++; $display("FAIL wrr_r1: got rvalid=%0b data=%h want 1/%h", obs_rvalid, obs_rdata, d1); end
        avm_main_readdatavalid = 1'b0;
        tick();
        n_checks++; if (obs_rvalid !== 1'b1 || obs_rdata !== d2) begin n_errors++; $display("FAIL wrr_r2: got rvalid=%0b data=%h want 1/%h", obs_rvalid, obs_rdata, d2); end
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL wrr_drained: got %0b want 0", obs_rvalid); end
    endtask

    task automatic test_err();
        logic want_err;
`ifdef AVALON_DATA_ERR_EN
        want_err = 1'b1;
`else
        want_err = 1'b0;
`endif
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 8'hFF; data_addr_i = $urandom();
            tick();
            idle();
            avm_main_readdatavalid = 1'b1; avm_main_readdata = {$urandom(), $urandom()};
            avm_main_response = (k == 0) ? 2'b10 : 2'b00;
            tick();
            idle();
            tick();
            n_checks++; if (obs_rvalid !== 1'b1) begin n_errors++; $display("FAIL err_rvalid_%0d: got %0b want 1", k, obs_rvalid); end
            n_checks++; if (obs_err !== (want_err && k == 0)) begin n_errors++; $display("FAIL err_flag_%0d: got %0b want %0b", k, obs_err, want_err && k == 0); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            data_addr_i = $urandom();
            tick();
            n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL mid_gnt_%0d: got %0b want 1", c, obs_gnt); end
        end
        rst_ni = 1'b0;
        tick();
        n_checks++; if (obs_read !== 1'b0 || obs_gnt !== 1'b0) begin n_errors++; $display("FAIL mid_cmd_in_reset: got read=%0b gnt=%0b want 0/0", obs_read, obs_gnt); end
        n_checks++; if (obs_rvalid !== 1'b0 || obs_rdata !== 64'h0 || obs_err !== 1'b0) begin n_errors++; $display("FAIL mid_outputs_in_reset: got %0b/%h/%0b want 0/0/0", obs_rvalid, obs_rdata, obs_err); end
        tick();
        rst_ni = 1'b1; idle();
        avm_main_readdatavalid = 1'b1; avm_main_readdata = {$urandom(), $urandom()};
        tick();
        n_checks++; if (obs_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_release_rvalid: got %0b want 0", obs_rvalid); end
        avm_main_readdatavalid = 1'b0;
        tick();
        n_checks++; if (obs_rvalid !== 1'b0 || obs_rdata !== 64'h0) begin n_errors++; $display("FAIL mid_dropped: got rvalid=%0b data=%h want 0/0", obs_rvalid, obs_rdata); end
        data_req_i = 1'b1; data_we_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_addr_i = $urandom();
            tick();
            n_checks++; if (obs_gnt !== 1'b1) begin n_errors++; $display("FAIL mid_empty_gnt_%0d: got %0b want 1", c, obs_gnt); end
        end
        idle();
    endtask

    task automatic test_random();
        bit pend = 1'b0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                data_req_i   = ($urandom_range(0, 3) != 0);
                data_we_i    = $urandom_range(0, 1) == 1;
                data_be_i    = 8'($urandom());
                data_addr_i  = $urandom();
                data_wdata_i = {$urandom(), $urandom()};
            end
            avm_main_waitrequest   = ($urandom_range(0, 3) == 0);
            avm_main_readdatavalid = (pending_reads() > 0) && ($urandom_range(0, 1) == 1);
            avm_main_readdata      = {$urandom(), $urandom()};
            avm_main_response      = 2'($urandom());
            tick();
            n_checks++; if (obs_gnt !== exp_gnt) begin n_errors++; $display("FAIL rnd_gnt c%0d: got %0b want %0b", c, obs_gnt, exp_gnt); end
            n_checks++; if (obs_read !== exp_read || obs_write !== exp_write) begin n_errors++; $display("FAIL rnd_cmd c%0d: got r=%0b w=%0b want r=%0b w=%0b", c, obs_read, obs_write, exp_read, exp_write); end
            n_checks++; if (obs_rvalid !== exp_rvalid) begin n_errors++; $display("FAIL rnd_rvalid c%0d: got %0b want %0b", c, obs_rvalid, exp_rvalid); end
            if (exp_rvalid) begin
                n_checks++; if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin n_errors++; $display("FAIL rnd_resp c%0d: got %h/%0b want %h/%0b", c, obs_rdata, obs_err, exp_rdata, exp_err); end
            end
            pend = data_req_i && !obs_gnt;
        end
        idle();
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        test_reset();
        test_single_read();
        test_write_wait();
        test_full();
        test_wrr();
        test_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
